// File: rtl/fg_trigger_scheduler.sv
// Schedules detector triggers from fast-gate rising edges within a start-enabled run window.
// Optional FG_WINDOW_CHECK_EN suppresses a trigger if the gate has already closed at delay expiry.
module fg_trigger_scheduler #(
    parameter int SYNC_STAGES = 2,
    parameter int DLY_W       = 24,
    parameter int PULSE_LEN   = 40,
    parameter int HOLDOFF     = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_signal,
    input  logic             fg_signal,
    input  logic             detector_ready,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_shots,
    output logic             output_trigger,
    output logic [2:0]       scenario_state,
    output logic [CNT_W-1:0] shot_count,
    output logic [CNT_W-1:0] missed_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        DELAY    = 3'd2,
        FIRE     = 3'd3,
        WAIT_RDY = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam int HW = $clog2(HOLDOFF + 2);
    localparam logic [PW-1:0]    PULSE_LAST = PW'(PULSE_LEN - 1);
    localparam logic [HW-1:0]    HOLD_END   = HW'(HOLDOFF);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [SYNC_STAGES-1:0] start_sync, fg_sync, rdy_sync;
    logic                   start_s, fg_s, rdy_s;
    logic                   start_s_d, fg_s_d, start_rise, fg_rise;

    state_t           state;
    logic [CNT_W-1:0] shots_lat;
    logic [DLY_W-1:0] delay_lat;
    logic [DLY_W-1:0] dly_cnt;
    logic [PW-1:0]    pulse_cnt;
    logic [HW-1:0]    hold_cnt;

    logic delay_done, zero_fire, fire_req, window_ok;

    assign start_s = start_sync[SYNC_STAGES-1];
    assign fg_s    = fg_sync[SYNC_STAGES-1];
    assign rdy_s   = rdy_sync[SYNC_STAGES-1];

    // Synchronisers plus registered edge pulses, so the FSM sees one clean event cycle per edge
    always_ff @(posedge clock) begin
        if (reset) begin
            start_sync <= '0;
            fg_sync    <= '0;
            rdy_sync   <= '0;
            start_s_d  <= 1'b0;
            fg_s_d     <= 1'b0;
            start_rise <= 1'b0;
            fg_rise    <= 1'b0;
        end else begin
            start_sync[0] <= start_signal;
            fg_sync[0]    <= fg_signal;
            rdy_sync[0]   <= detector_ready;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                start_sync[i] <= start_sync[i-1];
                fg_sync[i]    <= fg_sync[i-1];
                rdy_sync[i]   <= rdy_sync[i-1];
            end
            start_s_d  <= start_s;
            fg_s_d     <= fg_s;
            start_rise <= start_s & ~start_s_d;
            fg_rise    <= fg_s & ~fg_s_d;
        end
    end

    assign delay_done = (state == DELAY) && start_s && (dly_cnt == delay_lat - 1'b1);
    assign zero_fire  = (state == ARMED) && start_s && fg_rise && rdy_s && (cfg_delay == '0);
    assign fire_req   = delay_done | zero_fire;

`ifdef FG_WINDOW_CHECK_EN
    assign window_ok = fg_s;
`else
    assign window_ok = 1'b1;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            output_trigger <= 1'b0;
            shot_count     <= '0;
            missed_count   <= '0;
            shots_lat      <= '0;
            delay_lat      <= '0;
            dly_cnt        <= '0;
            pulse_cnt      <= '0;
            hold_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state        <= ARMED;
                        shot_count   <= '0;
                        missed_count <= '0;
                        shots_lat    <= cfg_shots;
                    end
                end
                ARMED: begin
                    if (!start_s) begin
                        state <= IDLE;
                    end else if (fire_req) begin
                        if (window_ok) begin
                            state          <= FIRE;
                            output_trigger <= 1'b1;
                            shot_count     <= sat_inc(shot_count);
                            pulse_cnt      <= '0;
                        end else begin
                            missed_count <= sat_inc(missed_count);
                        end
                    end else if (fg_rise && rdy_s) begin
                        state     <= DELAY;
                        delay_lat <= cfg_delay;
                        dly_cnt   <= '0;
                    end else if (fg_rise) begin
                        missed_count <= sat_inc(missed_count);
                    end
                end
                DELAY: begin
                    if (!start_s) begin
                        state <= IDLE;
                    end else if (fire_req) begin
                        if (window_ok) begin
                            state          <= FIRE;
                            output_trigger <= 1'b1;
                            shot_count     <= sat_inc(shot_count);
                            pulse_cnt      <= '0;
                        end else begin
                            state        <= ARMED;
                            missed_count <= sat_inc(missed_count);
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                // Pulse length is fixed once started; start_s is deliberately not looked at here
                FIRE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state          <= WAIT_RDY;
                        output_trigger <= 1'b0;
                        hold_cnt       <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (fg_rise) begin
                        missed_count <= sat_inc(missed_count);
                    end
                    if (hold_cnt != HOLD_END) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (rdy_s) begin
                        if (shots_lat != '0 && shot_count == shots_lat) begin
                            state <= DONE;
                        end else if (start_s) begin
                            state <= ARMED;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (!start_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign scenario_state = state;
    assign busy           = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_fg_trigger_scheduler.sv
// Bench for fg_trigger_scheduler: vector table, directed corner sequences and a randomized
// run checked against a shot/miss bookkeeping model.
module tb_fg_trigger_scheduler;

    localparam int SYNC_STAGES = 2;
    localparam int DLY_W       = 24;
    localparam int PULSE_LEN   = 40;
    localparam int HOLDOFF     = 16;
    localparam int CNT_W       = 16;

    logic             clock;
    logic             reset;
    logic             start_signal;
    logic             fg_signal;
    logic             detector_ready;
    logic [DLY_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_shots;
    logic             output_trigger;
    logic [2:0]       scenario_state;
    logic [CNT_W-1:0] shot_count;
    logic [CNT_W-1:0] missed_count;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    fg_trigger_scheduler #(
        .SYNC_STAGES(SYNC_STAGES),
        .DLY_W      (DLY_W),
        .PULSE_LEN  (PULSE_LEN),
        .HOLDOFF    (HOLDOFF),
        .CNT_W      (CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start_signal   (start_signal),
        .fg_signal      (fg_signal),
        .detector_ready (detector_ready),
        .cfg_delay      (cfg_delay),
        .cfg_shots      (cfg_shots),
        .output_trigger (output_trigger),
        .scenario_state (scenario_state),
        .shot_count     (shot_count),
        .missed_count   (missed_count),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int dly;
        bit rdy;
        int fg_len;
        int exp_lat;
        int exp_width;
        int exp_shots;
        int exp_missed;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One FG gate: returns the edge index (first sampling edge = 1) of the first trigger cycle and its width
    task automatic applyStimulus(input int dly, input bit rdy, input int fg_len, input bit drop_rdy,
                                 output int lat, output int width);
        cfg_delay      = DLY_W'(dly);
        detector_ready = rdy;
        tick(6);
        fg_signal = 1'b1;
        lat   = 0;
        width = 0;
        for (int k = 1; k <= dly + fg_len + PULSE_LEN + 40; k++) begin
            tick(1);
            if (output_trigger) begin
                if (lat == 0) begin
                    lat = k;
                    if (drop_rdy) detector_ready = 1'b0;
                end
                if (k == lat + width) width++;
            end
            if (k == fg_len) fg_signal = 1'b0;
        end
        fg_signal = 1'b0;
    endtask

    task automatic busyEdge();
        tick(2);
        fg_signal = 1'b1;
        tick(5);
        fg_signal = 1'b0;
        tick(10);
        detector_ready = 1'b1;
        tick(30);
    endtask

    task automatic startRun(input int shots);
        cfg_shots    = CNT_W'(shots);
        start_signal = 1'b1;
        tick(6);
    endtask

    task automatic stopRun();
        start_signal = 1'b0;
        tick(6);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   lat, w, saw, got;
        int   lim, m_shots, m_missed, d, fgl;
        bit   done, rdy, bsy;

        vecs[0] = '{0,  1, 12, 4,  40, 1, 0};
        vecs[1] = '{1,  1, 12, 5,  40, 2, 0};
        vecs[2] = '{7,  1, 20, 11, 40, 3, 0};
        vecs[3] = '{3,  0, 15, 0,  0,  3, 1};
        vecs[4] = '{25, 1, 40, 29, 40, 4, 1};
        vecs[5] = '{2,  0, 12, 0,  0,  4, 2};

        reset          = 1'b1;
        start_signal   = 1'b0;
        fg_signal      = 1'b0;
        detector_ready = 1'b0;
        cfg_delay      = '0;
        cfg_shots      = '0;
        tick(20);
        checkOutput("reset_trigger", output_trigger, 0);
        checkOutput("reset_state", scenario_state, 0);
        checkOutput("reset_shots", shot_count, 0);
        checkOutput("reset_missed", missed_count, 0);
        checkOutput("reset_busy", busy, 0);
        reset = 1'b0;
        tick(3);
        checkOutput("idle_state", scenario_state, 0);

        // Vector table, unlimited run
        startRun(0);
        checkOutput("armed_state", scenario_state, 1);
        checkOutput("armed_busy", busy, 1);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dly, vecs[i].rdy, vecs[i].fg_len, 1'b0, lat, w);
            checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            checkOutput($sformatf("vec%0d_width", i), w, vecs[i].exp_width);
            checkOutput($sformatf("vec%0d_shots", i), shot_count, vecs[i].exp_shots);
            checkOutput($sformatf("vec%0d_missed", i), missed_count, vecs[i].exp_missed);
            checkOutput($sformatf("vec%0d_state", i), scenario_state, 1);
        end
        stopRun();
        checkOutput("vec_stop_state", scenario_state, 0);
        checkOutput("vec_stop_shots_hold", shot_count, 4);
        checkOutput("vec_stop_missed_hold", missed_count, 2);

        // Single-shot run ends in DONE and ignores further gates
        startRun(1);
        checkOutput("run_clears_shots", shot_count, 0);
        applyStimulus(40, 1'b1, 50, 1'b0, lat, w);
        checkOutput("basic_latency", lat, SYNC_STAGES + 2 + 40);
        checkOutput("basic_width", w, PULSE_LEN);
        checkOutput("basic_shots", shot_count, 1);
        checkOutput("basic_state_done", scenario_state, 5);
        checkOutput("basic_busy", busy, 0);
        applyStimulus(5, 1'b1, 15, 1'b0, lat, w);
        checkOutput("done_no_trigger", lat, 0);
        checkOutput("done_shots_hold", shot_count, 1);
        checkOutput("done_missed_hold", missed_count, 0);
        stopRun();
        checkOutput("done_to_idle", scenario_state, 0);

        // Abort in the middle of a long delay
        startRun(0);
        cfg_delay      = DLY_W'(400);
        detector_ready = 1'b1;
        tick(6);
        fg_signal = 1'b1;
        saw = 0;
        for (int k = 1; k <= 100; k++) begin
            tick(1);
            if (output_trigger) saw = 1;
            if (k == 10) fg_signal = 1'b0;
            if (k == 50) checkOutput("abort_in_delay", scenario_state, 2);
        end
        start_signal = 1'b0;
        for (int k = 0; k < 500; k++) begin
            tick(1);
            if (output_trigger) saw = 1;
        end
        checkOutput("abort_no_trigger", saw, 0);
        checkOutput("abort_state", scenario_state, 0);
        checkOutput("abort_shots", shot_count, 0);

        // Reset during the 10th cycle of the pulse
        startRun(0);
        cfg_delay      = DLY_W'(5);
        detector_ready = 1'b1;
        tick(6);
        fg_signal = 1'b1;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            tick(1);
            if (output_trigger) got = 1;
        end
        checkOutput("rst_pulse_seen", got, 1);
        tick(9);
        checkOutput("rst_pulse_cycle10", output_trigger, 1);
        reset = 1'b1;
        tick(1);
        checkOutput("rst_trigger_drop", output_trigger, 0);
        checkOutput("rst_state", scenario_state, 0);
        checkOutput("rst_shots", shot_count, 0);
        checkOutput("rst_missed", missed_count, 0);
        reset        = 1'b0;
        fg_signal    = 1'b0;
        start_signal = 1'b0;
        tick(10);

        // Gate closes long before the delay expires
        startRun(0);
        applyStimulus(30, 1'b1, 5, 1'b0, lat, w);
`ifdef FG_WINDOW_CHECK_EN
        checkOutput("window_latency", lat, 0);
        checkOutput("window_shots", shot_count, 0);
        checkOutput("window_missed", missed_count, 1);
`else
        checkOutput("window_latency", lat, SYNC_STAGES + 2 + 30);
        checkOutput("window_shots", shot_count, 1);
        checkOutput("window_missed", missed_count, 0);
`endif
        checkOutput("window_state", scenario_state, 1);
        stopRun();

        // Randomized runs against a shot/miss bookkeeping model
        for (int r = 0; r < 3; r++) begin
            lim = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 6));
            startRun(lim);
            m_shots  = 0;
            m_missed = 0;
            done     = 1'b0;
            for (int e = 0; e < 10; e++) begin
                d   = int'($urandom_range(0, 60));
                rdy = ($urandom_range(0, 3) != 0);
                bsy = rdy && ($urandom_range(0, 2) == 0);
                fgl = d + 8 + int'($urandom_range(0, 20));
                applyStimulus(d, rdy, fgl, bsy, lat, w);
                if (bsy) busyEdge();
                if (!done) begin
                    if (rdy) begin
                        checkOutput($sformatf("rnd%0d_%0d_latency", r, e), lat, SYNC_STAGES + 2 + d);
                        checkOutput($sformatf("rnd%0d_%0d_width", r, e), w, PULSE_LEN);
                        m_shots++;
                        if (bsy) m_missed++;
                        if (lim != 0 && m_shots == lim) done = 1'b1;
                    end else begin
                        checkOutput($sformatf("rnd%0d_%0d_no_trigger", r, e), lat, 0);
                        m_missed++;
                    end
                end else begin
                    checkOutput($sformatf("rnd%0d_%0d_done_quiet", r, e), lat, 0);
                end
                checkOutput($sformatf("rnd%0d_%0d_shots", r, e), shot_count, m_shots);
                checkOutput($sformatf("rnd%0d_%0d_missed", r, e), missed_count, m_missed);
                checkOutput($sformatf("rnd%0d_%0d_state", r, e), scenario_state, done ? 5 : 1);
                checkOutput($sformatf("rnd%0d_%0d_busy", r, e), busy, done ? 0 : 1);
            end
            stopRun();
            checkOutput($sformatf("rnd%0d_end_state", r), scenario_state, 0);
            checkOutput($sformatf("rnd%0d_end_shots", r), shot_count, m_shots);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
